gat_stage_scheduler: RTL and testbench

Sequences the four GAT compute stages (SPMM, DMVM, softmax, aggregation) across all nodes and layers of one inference run. It issues per-node start pulses and tracks per-stage completions. SPMM runs as a full barrier per layer; DMVM, softmax and aggregation run as a node-level wavefront with one node in flight per stage. It also exports a sticky status word for the debug readout path.

---
 rtl/gat_pkg.sv | 37 +++
 rtl/gat_stage_scheduler_stage_tracker.sv | 55 +++++
 rtl/gat_stage_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_gat_stage_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT stage scheduler and its debug readout.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gat_pkg;

  // Scheduler FSM states; the encoding is visible in status_o[3:0].
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPMM      = 3'd1,
    ST_ATTN      = 3'd2,
    ST_LAYER_END = 3'd3,
    ST_FIN       = 3'd4
  } sched_state_e;

  // Stage indices used for the go/done/perf vectors.
  localparam int STG_SPMM = 0;
  localparam int STG_DMVM = 1;
  localparam int STG_SM   = 2;
  localparam int STG_AGGR = 3;
  localparam int NUM_STG  = 4;

  // Status word bit positions, shared with the debug readout decoder.
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_STATE_W   = 4;
  localparam int STAT_AGGR_SEEN = 4;
  localparam int STAT_SM_SEEN   = 5;
  localparam int STAT_DMVM_SEEN = 6;
  localparam int STAT_SPMM_SEEN = 7;
  localparam int STAT_BUSY      = 8;
  localparam int STAT_ERR       = 9;

  // Width of the layer index; a single-layer build still gets one bit.
  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gat_stage_scheduler_stage_tracker.sv
// Per-stage node tracker: issued/completed counts, idle, eligibility, go/node regs, spurious-done detect.
// Latency: done_i in cycle t allows the next go to be visible at t+1 (eligibility uses post-done counts).
// Backpressure: one node in flight; a new go is issued only once the previous node has completed.
module stage_tracker
  import gat_pkg::*;
#(
  parameter int NODE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [NODE_W:0]   limit,
  input  logic              done,
  output logic              go,
  output logic [NODE_W-1:0] node,
  output logic [NODE_W:0]   cmpl_nxt,
  output logic              idle,
  output logic              spur
);

  logic [NODE_W:0] issued;
  logic [NODE_W:0] completed;
  logic            elig;

  // A done while idle is spurious and never moves the completed count.
  always_comb begin
    idle     = (issued == completed);
    spur     = done && idle;
    cmpl_nxt = completed + {{NODE_W{1'b0}}, (done && !idle)};
    elig     = en && (issued == cmpl_nxt) && (issued < limit);
  end

  // Counters and go/node registers; node holds its value between gos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued    <= '0;
      completed <= '0;
      go        <= 1'b0;
      node      <= '0;
    end else if (clr) begin
      issued    <= '0;
      completed <= '0;
      go        <= 1'b0;
    end else begin
      issued    <= issued + {{NODE_W{1'b0}}, elig};
      completed <= cmpl_nxt;
      go        <= elig;
      if (elig) begin
        node <= issued[NODE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gat_stage_scheduler.sv
// Sequences SPMM (per-layer barrier) then DMVM/softmax/aggregation (node wavefront) over all layers.
// Latency: start -> busy +1, first spmm go +2; last aggr done -> next layer go / done_o +3.
// Backpressure: each stage waits for its own done and its upstream completions; start ignored when busy.
// Optional per-stage busy-cycle counters on perf_o are built when GAT_SCHED_PERF_CNT_EN is defined.
module gat_stage_scheduler
  import gat_pkg::*;
#(
  parameter int NUM_NODES  = 2708,
  parameter int NUM_LAYERS = 2,
  parameter int NODE_W     = 16,
  parameter int CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [layer_w(NUM_LAYERS)-1:0] layer_o,
  output logic                           spmm_go_o,
  output logic                           dmvm_go_o,
  output logic                           sm_go_o,
  output logic                           aggr_go_o,
  output logic [NODE_W-1:0]              spmm_node_o,
  output logic [NODE_W-1:0]              dmvm_node_o,
  output logic [NODE_W-1:0]              sm_node_o,
  output logic [NODE_W-1:0]              aggr_node_o,
  input  logic                           spmm_done_i,
  input  logic                           dmvm_done_i,
  input  logic                           sm_done_i,
  input  logic                           aggr_done_i,
  output logic                           err_o,
  output logic [31:0]                    status_o,
  output logic [4*CNT_W-1:0]             perf_o
);

  localparam int              LW         = layer_w(NUM_LAYERS);
  localparam logic [NODE_W:0] NODES      = (NODE_W+1)'(NUM_NODES);
  localparam logic [LW-1:0]   LAST_LAYER = LW'(NUM_LAYERS - 1);

  sched_state_e state, state_nxt;
  logic clr, spmm_en, attn_en, accept, layer_step, fin;

  logic [NUM_STG-1:0] done_in, go, spur, idle, en;
  logic [NUM_STG-1:0] seen;
  logic [NODE_W:0]    limit    [NUM_STG];
  logic [NODE_W:0]    cmpl_nxt [NUM_STG];
  logic [NODE_W-1:0]  node     [NUM_STG];

  logic busy, done_p, err;
  logic [LW-1:0] layer;

  assign done_in = {aggr_done_i, sm_done_i, dmvm_done_i, spmm_done_i};

  // SPMM and DMVM walk the whole node list; SM and AGGR trail their upstream completions.
  always_comb begin
    limit[STG_SPMM] = NODES;
    limit[STG_DMVM] = NODES;
    limit[STG_SM]   = cmpl_nxt[STG_DMVM];
    limit[STG_AGGR] = cmpl_nxt[STG_SM];
    en              = {attn_en, attn_en, attn_en, spmm_en};
  end

  for (genvar g = 0; g < NUM_STG; g++) begin : g_trk
    stage_tracker #(.NODE_W(NODE_W)) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .en       (en[g]),
      .limit    (limit[g]),
      .done     (done_in[g]),
      .go       (go[g]),
      .node     (node[g]),
      .cmpl_nxt (cmpl_nxt[g]),
      .idle     (idle[g]),
      .spur     (spur[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt  = state;
    clr        = 1'b0;
    spmm_en    = 1'b0;
    attn_en    = 1'b0;
    accept     = 1'b0;
    layer_step = 1'b0;
    fin        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          clr       = 1'b1;
          state_nxt = ST_SPMM;
        end
      end
      ST_SPMM: begin
        spmm_en = 1'b1;
        if (cmpl_nxt[STG_SPMM] == NODES) state_nxt = ST_ATTN;
      end
      ST_ATTN: begin
        attn_en = 1'b1;
        if (cmpl_nxt[STG_AGGR] == NODES) state_nxt = ST_LAYER_END;
      end
      ST_LAYER_END: begin
        clr        = 1'b1;
        layer_step = 1'b1;
        state_nxt  = (layer == LAST_LAYER) ? ST_FIN : ST_SPMM;
      end
      ST_FIN: begin
        fin       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run-level registers: busy, done pulse, layer index, sticky error and seen flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done_p <= 1'b0;
      layer  <= '0;
      err    <= 1'b0;
      seen   <= '0;
    end else begin
      done_p <= fin;
      if (accept)   busy <= 1'b1;
      else if (fin) busy <= 1'b0;
      // Final layer wraps to 0 so layer_o idles at the reset value.
      if (layer_step) layer <= (layer == LAST_LAYER) ? '0 : layer + LW'(1);
      if (accept)     err <= 1'b0;
      else if (|spur) err <= 1'b1;
      if (accept) seen <= '0;
      else        seen <= seen | go;
    end
  end

  assign busy_o      = busy;
  assign done_o      = done_p;
  assign layer_o     = layer;
  assign err_o       = err;
  assign spmm_go_o   = go[STG_SPMM];
  assign dmvm_go_o   = go[STG_DMVM];
  assign sm_go_o     = go[STG_SM];
  assign aggr_go_o   = go[STG_AGGR];
  assign spmm_node_o = node[STG_SPMM];
  assign dmvm_node_o = node[STG_DMVM];
  assign sm_node_o   = node[STG_SM];
  assign aggr_node_o = node[STG_AGGR];

  // Status word is a plain concatenation of flop outputs.
  always_comb begin
    status_o                                    = '0;
    status_o[STAT_STATE_LSB +: STAT_STATE_W]    = {1'b0, state};
    status_o[STAT_AGGR_SEEN]                    = seen[STG_AGGR];
    status_o[STAT_SM_SEEN]                      = seen[STG_SM];
    status_o[STAT_DMVM_SEEN]                    = seen[STG_DMVM];
    status_o[STAT_SPMM_SEEN]                    = seen[STG_SPMM];
    status_o[STAT_BUSY]                         = busy;
    status_o[STAT_ERR]                          = err;
  end

`ifdef GAT_SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] perf [NUM_STG];

  // Saturating busy-cycle counters, restarted on every accepted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STG; k++) perf[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STG; k++) begin
        if (accept)                          perf[k] <= '0;
        else if (!idle[k] && (perf[k] != '1)) perf[k] <= perf[k] + CNT_W'(1);
      end
    end
  end

  // Pack counters into perf_o by stage index.
  always_comb begin
    perf_o = '0;
    for (int k = 0; k < NUM_STG; k++) perf_o[k*CNT_W +: CNT_W] = perf[k];
  end
`else
  logic unused_idle;
  assign unused_idle = &{1'b0, idle};
  assign perf_o      = '0;
`endif

endmodule

// File: tb/tb_gat_stage_scheduler.sv
// Directed bench for gat_stage_scheduler with 4 nodes, 2 layers and a latency-programmable done responder.
// Latency: responder answers done lat[k] cycles after each go.
// Backpressure: responder holds one node per stage, mirroring the scheduler's single in-flight node.
module tb_gat_stage_scheduler;

  localparam int NN = 4;
  localparam int NL = 2;
  localparam int NW = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [3:0]    dvec;
  logic          busy, done, err;
  logic [0:0]    layer;
  logic          spmm_go, dmvm_go, sm_go, aggr_go;
  logic [NW-1:0] spmm_node, dmvm_node, sm_node, aggr_node;
  logic [31:0]   status;
  logic [4*CW-1:0] perf;

  gat_stage_scheduler #(.NUM_NODES(NN), .NUM_LAYERS(NL), .NODE_W(NW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .layer_o(layer),
    .spmm_go_o(spmm_go), .dmvm_go_o(dmvm_go), .sm_go_o(sm_go), .aggr_go_o(aggr_go),
    .spmm_node_o(spmm_node), .dmvm_node_o(dmvm_node), .sm_node_o(sm_node), .aggr_node_o(aggr_node),
    .spmm_done_i(dvec[0]), .dmvm_done_i(dvec[1]), .sm_done_i(dvec[2]), .aggr_done_i(dvec[3]),
    .err_o(err), .status_o(status), .perf_o(perf)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat [4];
  int cd [4];
  int go_cnt [4];
  int dn_cnt [4];
  int node_err, order_viol, aggr_viol, done_cnt, done_cyc;
  int aggr4_cyc, aggr8_cyc, spmm2_cyc, layer_at_aggr, dmvm_at_sm1;
  int exp_perf;
  logic prev_layer;
  logic [3:0] inj;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs, update the bookkeeping, then drive this cycle's dones.
  task automatic tick();
    logic [3:0]    g;
    logic [3:0]    d;
    logic [NW-1:0] nd [4];
    @(posedge clk);
    #1;
    cyc++;
    g = {aggr_go, sm_go, dmvm_go, spmm_go};
    nd[0] = spmm_node; nd[1] = dmvm_node; nd[2] = sm_node; nd[3] = aggr_node;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if (cd[k] > 0) begin
        cd[k]--;
        if (cd[k] == 0) d[k] = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (g[k]) begin
        if (int'(nd[k]) != go_cnt[k] % NN) node_err++;
        if (k == 1 && dn_cnt[0] < NN * (go_cnt[1] / NN + 1)) order_viol++;
        if (k == 3 && dn_cnt[2] < go_cnt[3] + 1) aggr_viol++;
        if (k == 0 && go_cnt[0] == NN) spmm2_cyc = cyc;
        go_cnt[k]++;
        cd[k] = lat[k];
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (layer != prev_layer) begin
      if (layer == 1'b1) layer_at_aggr = dn_cnt[3];
      prev_layer = layer;
    end
    for (int k = 0; k < 4; k++) if (d[k]) dn_cnt[k]++;
    if (d[3] && dn_cnt[3] == NN)     aggr4_cyc = cyc;
    if (d[3] && dn_cnt[3] == 2 * NN) aggr8_cyc = cyc;
    if (d[2] && dn_cnt[2] == 1)      dmvm_at_sm1 = go_cnt[1];
    dvec = d | inj;
    inj  = '0;
  endtask

  task automatic reset_stats();
    for (int k = 0; k < 4; k++) begin
      go_cnt[k] = 0;
      dn_cnt[k] = 0;
    end
    node_err = 0; order_viol = 0; aggr_viol = 0; done_cnt = 0; done_cyc = -1;
    aggr4_cyc = -1; aggr8_cyc = -1; spmm2_cyc = -1; layer_at_aggr = -1; dmvm_at_sm1 = -1;
  endtask

  task automatic start_run(input string tag);
    reset_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_t1"}, busy, 1);
    check({tag, "_no_go_t1"}, spmm_go, 0);
    tick();
    check({tag, "_spmm_go_t2"}, spmm_go, 1);
    check({tag, "_spmm_node_t2"}, spmm_node, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check({tag, "_finished"}, (done_cnt > 0), 1);
    repeat (3) tick();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_spmm_gos"}, go_cnt[0], 2 * NN);
    check({tag, "_dmvm_gos"}, go_cnt[1], 2 * NN);
    check({tag, "_sm_gos"},   go_cnt[2], 2 * NN);
    check({tag, "_aggr_gos"}, go_cnt[3], 2 * NN);
    check({tag, "_node_order"}, node_err, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dvec  = '0;
    inj   = '0;
    prev_layer = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lat[k] = 3;
      cd[k]  = 0;
    end
`ifdef GAT_SCHED_PERF_CNT_EN
    exp_perf = 2 * NN * 4;
`else
    exp_perf = 0;
`endif
    reset_stats();

    // Reset values
    #3;
    check("rst_ctrl", {busy, done, err, layer, spmm_go, dmvm_go, sm_go, aggr_go}, 0);
    check("rst_nodes", {spmm_node, dmvm_node, sm_node, aggr_node}, 0);
    check("rst_status", status, 0);
    check("rst_perf", perf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Run 1: all stages answer 3 cycles after go
    start_run("r1");
    wait_done("r1", 1000);
    check_counts("r1");
    check("r1_dmvm_after_spmm", order_viol, 0);
    check("r1_aggr_after_sm", aggr_viol, 0);
    check("r1_seen", status[7:4], 4'hF);
    check("r1_state_idle", status[3:0], 0);
    check("r1_layer_step_at_4th_aggr", layer_at_aggr, NN);
    check("r1_l2_spmm_delay", spmm2_cyc - aggr4_cyc, 3);
    check("r1_done_delay", done_cyc - aggr8_cyc, 3);
    check("r1_layer_idle", layer, 0);
    check("r1_err", err, 0);
    for (int k = 0; k < 4; k++) check($sformatf("r1_perf%0d", k), perf[k*CW +: CW], exp_perf);

    // Run 2: softmax answers slowly, DMVM must keep streaming
    lat[2] = 10;
    start_run("r2");
    wait_done("r2", 2000);
    check_counts("r2");
    check("r2_dmvm_ahead_of_sm", dmvm_at_sm1, NN);
    check("r2_aggr_after_sm", aggr_viol, 0);
    check("r2_dmvm_after_spmm", order_viol, 0);
    lat[2] = 3;

    // Run 3: spurious aggr done during SPMM
    start_run("r3");
    inj[3] = 1'b1;
    tick();
    tick();
    check("r3_err_set", err, 1);
    check("r3_status_err", status[9], 1);
    wait_done("r3", 1000);
    check_counts("r3");
    check("r3_err_sticky", err, 1);

    // Run 4: accepted start clears err, then reset while DMVM and SM are in flight
    start_run("r4");
    check("r4_err_cleared", err, 0);
    for (int i = 0; i < 200 && !(status[3:0] == 4'd2 && cd[1] > 0 && cd[2] > 0); i++) tick();
    check("r4_attn_inflight", (status[3:0] == 4'd2 && cd[1] > 0 && cd[2] > 0), 1);
    rst_n = 1'b0;
    #1;
    check("r4_rst_ctrl", {busy, done, err, layer, spmm_go, dmvm_go, sm_go, aggr_go}, 0);
    check("r4_rst_nodes", {spmm_node, dmvm_node, sm_node, aggr_node}, 0);
    check("r4_rst_status", status, 0);
    check("r4_rst_perf", perf, 0);
    for (int k = 0; k < 4; k++) cd[k] = 0;
    dvec = '0;
    tick();
    rst_n = 1'b1;
    inj[1] = 1'b1;
    tick();
    tick();
    check("r4_late_done_err", err, 1);

    // Run 5: clean pass after reset
    start_run("r5");
    check("r5_err_cleared", err, 0);
    wait_done("r5", 1000);
    check_counts("r5");
    check("r5_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
